// File: rtl/inst_encoder.sv
// Encodes RV32 I/S/B instructions from field inputs and queues the results in a
// small FIFO; out-of-range immediates become a NOP entry flagged as an error.
module inst_encoder #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [1:0]               in_fmt,
    input  logic [4:0]               in_rd,
    input  logic [4:0]               in_rs1,
    input  logic [4:0]               in_rs2,
    input  logic [2:0]               in_funct3,
    input  logic [31:0]              in_imm,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_inst,
    output logic                     out_err,
    output logic [$clog2(DEPTH):0]   count,
    output logic [7:0]               err_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    logic [32:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [7:0]    r_err_cnt;
    logic          r_rdy_en;

    logic          w_push;
    logic          w_pop;
    logic          w_err;
    logic [31:0]   w_inst;
    logic [32:0]   w_head;

    always_comb begin
        w_inst = '0;
        w_err  = 1'b0;
        unique case (in_fmt)
            2'b00: begin
                w_inst = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0000011};
                w_err  = ($signed(in_imm) < -32'sd2048) || ($signed(in_imm) > 32'sd2047);
            end
            2'b01: begin
                w_inst = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0010011};
                w_err  = ($signed(in_imm) < -32'sd2048) || ($signed(in_imm) > 32'sd2047);
            end
            2'b10: begin
                w_inst = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], 7'b0100011};
                w_err  = ($signed(in_imm) < -32'sd2048) || ($signed(in_imm) > 32'sd2047);
            end
            default: begin
                w_inst = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                          in_imm[4:1], in_imm[11], 7'b1100011};
                w_err  = ($signed(in_imm) < -32'sd4096) || ($signed(in_imm) > 32'sd4094)
                         || in_imm[0];
            end
        endcase
        if (w_err) begin
            w_inst = NOP_INST;
        end
    end

    // in_ready stays low until the first clock after reset release
    assign in_ready  = r_rdy_en && (r_count < CW'(DEPTH));
    assign out_valid = (r_count != '0);
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;
    assign w_head    = r_mem[r_rd_ptr];
    assign out_inst  = out_valid ? w_head[31:0] : '0;
    assign out_err   = out_valid ? w_head[32] : 1'b0;
    assign count     = r_count;
    assign err_cnt   = r_err_cnt;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {w_err, w_inst};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_err_cnt <= '0;
            r_rdy_en  <= 1'b0;
        end else begin
            r_rdy_en <= 1'b1;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CW'(1);
            end
            if (w_push && w_err && (r_err_cnt != 8'hFF)) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_inst_encoder.sv
// Randomized and directed checks of inst_encoder against a queue-based reference.
module tb_inst_encoder;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  in_fmt = '0;
    logic [4:0]  in_rd = '0;
    logic [4:0]  in_rs1 = '0;
    logic [4:0]  in_rs2 = '0;
    logic [2:0]  in_funct3 = '0;
    logic [31:0] in_imm = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_inst;
    logic        out_err;
    logic [$clog2(DEPTH):0] count;
    logic [7:0]  err_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    logic [32:0] m_q [$];
    int          m_err_cnt = 0;
    bit          m_rdy_en  = 0;

    inst_encoder #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_fmt(in_fmt), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_imm(in_imm), .out_valid(out_valid),
        .out_ready(out_ready), .out_inst(out_inst), .out_err(out_err),
        .count(count), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: {err, inst} built from field arithmetic
    function automatic logic [32:0] ref_enc(int fmt, int rd, int rs1, int rs2, int f3, int imm);
        bit [31:0] inst;
        bit        err;
        if (fmt == 3) begin
            err  = (imm < -4096) || (imm > 4094) || ((imm & 1) != 0);
            inst = (((imm >> 12) & 1) << 31) | (((imm >> 5) & 63) << 25) | (rs2 << 20)
                 | (rs1 << 15) | (f3 << 12) | (((imm >> 1) & 15) << 8)
                 | (((imm >> 11) & 1) << 7) | 99;
        end else begin
            err = (imm < -2048) || (imm > 2047);
            if (fmt == 2)
                inst = (((imm >> 5) & 127) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12)
                     | ((imm & 31) << 7) | 35;
            else
                inst = ((imm & 4095) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7)
                     | ((fmt == 0) ? 3 : 19);
        end
        if (err) inst = 32'h13;
        return {err, inst};
    endfunction

    task automatic drive(input bit v, input int fmt, input int rd, input int rs1,
                         input int rs2, input int f3, input int imm, input bit ordy);
        in_valid  = v;
        in_fmt    = 2'(fmt);
        in_rd     = 5'(rd);
        in_rs1    = 5'(rs1);
        in_rs2    = 5'(rs2);
        in_funct3 = 3'(f3);
        in_imm    = 32'(imm);
        out_ready = ordy;
    endtask

    // Compare DUT against model, then advance one clock and update the model
    task automatic step();
        bit          exp_rdy;
        bit          push;
        bit          pop;
        logic [32:0] head;
        exp_rdy = m_rdy_en && (m_q.size() < DEPTH);
        head    = (m_q.size() > 0) ? m_q[0] : 33'd0;
        check("in_ready",  32'(in_ready),  32'(exp_rdy));
        check("out_valid", 32'(out_valid), 32'(m_q.size() > 0));
        check("out_inst",  out_inst,       head[31:0]);
        check("out_err",   32'(out_err),   32'(head[32]));
        check("count",     32'(count),     32'(m_q.size()));
        check("err_cnt",   32'(err_cnt),   32'(m_err_cnt));
        push = in_valid && exp_rdy;
        pop  = (m_q.size() > 0) && out_ready;
        @(posedge clk);
        if (pop) void'(m_q.pop_front());
        if (push) begin
            head = ref_enc(int'(in_fmt), int'(in_rd), int'(in_rs1), int'(in_rs2),
                           int'(in_funct3), $signed(in_imm));
            m_q.push_back(head);
            if (head[32] && m_err_cnt < 255) m_err_cnt++;
        end
        m_rdy_en = 1;
        #1;
    endtask

    function automatic int rand_imm();
        int edges[12] = '{-2048, 2047, 2048, -2049, -4096, 4094, 4095, 4096, -4097, 3, -8, 0};
        case ($urandom_range(0, 3))
            0: return edges[$urandom_range(0, 11)];
            1: return int'($urandom_range(0, 8191)) - 4096;
            2: return int'($urandom);
            default: return int'($urandom_range(0, 4095)) - 2048;
        endcase
    endfunction

    initial begin
        #3;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd0);
        check("rst_inst",  out_inst, 32'd0);
        #4 rst_n = 1'b1;
        @(posedge clk); #1;
        m_rdy_en = 1;

        drive(1, 0, 5, 2, 0, 2, -4, 1); step();
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        check("lw_inst", out_inst, 32'hFFC12283);
        check("lw_err",  32'(out_err), 32'd0);
        step();

        drive(1, 2, 0, 2, 6, 2, 8, 1); step();
        drive(1, 3, 0, 1, 2, 0, -8, 1);
        check("sw_inst", out_inst, 32'h00612423);
        step();
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        check("beq_inst", out_inst, 32'hFE208CE3);
        step();

        drive(1, 3, 0, 1, 2, 0, 3, 0); step();
        drive(1, 1, 4, 1, 0, 0, 2048, 0); step();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        check("err_cnt2", 32'(err_cnt), 32'd2);
        check("err1_inst", out_inst, 32'h13);
        check("err1_flag", 32'(out_err), 32'd1);
        step();
        out_ready = 1; step(); step();

        for (int i = 0; i < 5; i++) begin
            drive(1, $urandom_range(0, 3), $urandom_range(0, 31), $urandom_range(0, 31),
                  $urandom_range(0, 31), $urandom_range(0, 7), rand_imm(), 0);
            step();
        end
        check("full_count", 32'(count), 32'(DEPTH));
        check("full_ready", 32'(in_ready), 32'd0);
        out_ready = 1;
        for (int i = 0; i < 7; i++) step();
        in_valid = 0;
        for (int i = 0; i < 5; i++) step();
        check("drain_count", 32'(count), 32'd0);

        out_ready = 1;
        for (int i = 0; i < 10; i++) begin
            drive(1, $urandom_range(0, 2), $urandom_range(0, 31), $urandom_range(0, 31),
                  $urandom_range(0, 31), $urandom_range(0, 7), int'($urandom_range(0, 4095)) - 2048, 1);
            step();
            check("stream_count", 32'(count), 32'd1);
        end
        in_valid = 0; step();

        for (int i = 0; i < 2000; i++) begin
            drive($urandom_range(0, 9) < 7, $urandom_range(0, 3), $urandom_range(0, 31),
                  $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 7),
                  rand_imm(), $urandom_range(0, 9) < ((i / 200) % 2 == 0 ? 3 : 8));
            step();
        end

        drive(0, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < DEPTH + 1; i++) step();
        for (int i = 0; i < 300; i++) begin
            drive(1, 1, 1, 1, 0, 0, 5000, 1);
            step();
        end
        check("err_sat", 32'(err_cnt), 32'd255);

        drive(0, 0, 0, 0, 0, 0, 0, 1);
        step(); step();
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 7, 3, 0, 1, i + 1, 0);
            step();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        check("pre_rst_count", 32'(count), 32'd3);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_count", 32'(count), 32'd0);
        check("mid_rst_errcnt", 32'(err_cnt), 32'd0);
        check("mid_rst_ready", 32'(in_ready), 32'd0);
        check("mid_rst_inst", out_inst, 32'd0);
        #2 rst_n = 1'b1;
        m_q.delete();
        m_err_cnt = 0;
        m_rdy_en  = 0;
        out_ready = 1;
        for (int i = 0; i < 4; i++) step();
        for (int i = 0; i < 200; i++) begin
            drive($urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 31),
                  $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 7),
                  rand_imm(), $urandom_range(0, 1));
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/inst_encoder.md
INST_ENCODER -- requirements
Module: inst_encoder

Interface
REQ-001 Parameter: DEPTH, default 4, output FIFO entries (power of two, 2..16).
REQ-002 clk  input  1  rising-edge clock, single clock domain.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 in_valid  input  1  encode request present.
REQ-005 in_ready  output  1  request accepted on a cycle with in_valid=1 and in_ready=1.
REQ-006 in_fmt  input  2  format: 00 I-load (0000011), 01 I-alu (0010011), 10 S (0100011), 11 B (1100011).
REQ-007 in_rd, in_rs1, in_rs2  input  5 each  register fields.
REQ-008 in_funct3  input  3  funct3 field.
REQ-009 in_imm  input  32  signed two's-complement immediate (byte offset for B).
REQ-010 out_valid  output  1  FIFO head valid.
REQ-011 out_ready  input  1  consumer takes head when out_valid=1 and out_ready=1.
REQ-012 out_inst  output  32  encoded instruction at FIFO head.
REQ-013 out_err  output  1  head entry was an immediate-range error.
REQ-014 count  output  $clog2(DEPTH)+1  FIFO occupancy.
REQ-015 err_cnt  output  8  saturating count of accepted error requests.

Function
REQ-016 Encoding is performed combinationally on accepted inputs; the result is written into the FIFO in the accept cycle.
REQ-017 I formats: inst = {imm[11:0], rs1, funct3, rd, opcode}; in_rs2 ignored.
REQ-018 S format: inst = {imm[11:5], rs2, rs1, funct3, imm[4:0], 0100011}; in_rd ignored.
REQ-019 B format: inst = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], 1100011}; in_rd ignored.
REQ-020 Range error, I/S: in_imm outside [-2048, 2047]; B: in_imm outside [-4096, 4094] or in_imm[0]=1.
REQ-021 On range error the entry stores inst=32'h00000013 (addi x0,x0,0) with err=1; otherwise err=0.
REQ-022 Latency: accept in cycle N into an empty FIFO gives out_valid=1 with that entry in cycle N+1.
REQ-023 in_ready = (count < DEPTH); it does not depend combinationally on out_ready.
REQ-024 Strict FIFO order; entries are never dropped or duplicated.
REQ-025 Push and pop in the same cycle leave count unchanged; when count=0 only a push is possible.
REQ-026 When count=DEPTH, in_ready=0 and a same-cycle pop does not make room until the next cycle.
REQ-027 Read and write pointers wrap modulo DEPTH.
REQ-028 When out_valid=0: out_inst=0 and out_err=0.
REQ-029 err_cnt increments by 1 per accepted error request and saturates at 255.
REQ-030 out_inst and out_err remain stable while out_valid=1 and out_ready=0.

Reset
REQ-031 Asserting rst_n=0 immediately clears the following: count=0, pointers=0, out_valid=0, out_inst=0, out_err=0, err_cnt=0, in_ready=0.
REQ-032 in_ready returns to 1 on the first rising clk edge after rst_n deasserts.
REQ-033 Reset in mid-operation discards all FIFO contents; no pre-reset entry appears afterwards.

Verification
REQ-034 fmt=00, rd=5, rs1=2, f3=010, imm=-4, out_ready=1 -> next cycle out_inst=0xFFC12283, out_err=0.
REQ-035 fmt=10, rs1=2, rs2=6, f3=010, imm=8 -> out_inst=0x00612423; fmt=11, rs1=1, rs2=2, f3=000, imm=-8 -> out_inst=0xFE208CE3.
REQ-036 fmt=11, imm=3 then fmt=01, imm=2048 -> both entries out_inst=0x00000013, out_err=1, err_cnt=2.
REQ-037 out_ready=0, 5 back-to-back requests with DEPTH=4 -> count=4 and in_ready=0 after the 4th is accepted, 5th held; out_ready=1 -> 5 entries drain in order, count reaches 0.
REQ-038 Sustained push+pop with out_ready=1 for 10 cycles -> count constant at 1, one instruction output per cycle, pointers wrap.
REQ-039 rst_n pulsed low with count=3 mid-cycle -> out_valid=0, count=0 and err_cnt=0 immediately; no old entries are output after release.
